// File: rtl/qoa_pkg.sv
// Shared QOA slice constants, scalefactor table and field helpers for the
// slice unpacker and the dequantiser.
package qoa_pkg;

   localparam int QOA_SLICE_BYTES     = 8;
   localparam int QOA_SLICE_RESIDUALS = 20;
   localparam int QOA_SF_W            = 4;
   localparam int QOA_Q_W             = 3;
   localparam int QOA_MAG_W           = 15;

   // round((s+1)^2.75) for s = 0..15
   localparam logic [11:0] QOA_SF_TAB [16] = '{
      12'd1,    12'd7,    12'd21,   12'd45,
      12'd84,   12'd137,  12'd210,  12'd304,
      12'd421,  12'd563,  12'd731,  12'd928,
      12'd1157, 12'd1419, 12'd1715, 12'd2048
   };

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_EMIT    = 1'b1
   } unpack_state_e;

   function automatic logic [QOA_SF_W-1:0] slice_sf(input logic [63:0] slice);
      return slice[63:60];
   endfunction

   function automatic logic [QOA_Q_W-1:0] residual_field(input logic [63:0] slice,
                                                         input logic [4:0]  k);
      int base;
      residual_field = '0;
      base = 0;
      if (k < 5'(QOA_SLICE_RESIDUALS)) begin
         base = 59 - 3 * int'(k);
         residual_field = slice[base -: QOA_Q_W];
      end
   endfunction

endpackage

// File: rtl/qoa_dequant.sv
// Combinational QOA dequantiser: scalefactor index and 3-bit residual code
// to a signed, sign-extended residual value.
module qoa_dequant
   import qoa_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic [QOA_SF_W-1:0]  sf_quant,
   input  logic [QOA_Q_W-1:0]   q,
   output logic signed [OUT_W-1:0] res
);

   logic [QOA_MAG_W-1:0]    s;
   logic [QOA_MAG_W-1:0]    mag;
   logic signed [OUT_W-1:0] mag_ext;

   // Largest intermediate is 9*2048+1 = 18433, so 15 bits never wrap.
   always_comb begin
      s   = {3'b000, QOA_SF_TAB[sf_quant]};
      mag = '0;
      unique case (q[2:1])
         2'd0:    mag = ((s << 1) + s + 15'd2) >> 2;
         2'd1:    mag = ((s << 2) + s + 15'd1) >> 1;
         2'd2:    mag = ((s << 3) + s + 15'd1) >> 1;
         default: mag = (s << 3) - s;
      endcase
      mag_ext = $signed({{(OUT_W-QOA_MAG_W){1'b0}}, mag});
      res     = q[0] ? -mag_ext : mag_ext;
   end

endmodule

// File: rtl/qoa_slice_unpack.sv
// Assembles 8 received bytes into a QOA slice and streams its 20 dequantised
// residuals to the predictor with a valid/ready handshake.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_COLLECT | in_ready high, shifting bytes MSB-first into the slice
// ST_EMIT    | in_ready low, residual k held in output reg until accepted
module qoa_slice_unpack
   import qoa_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [OUT_W-1:0] res_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic                    res_last,
   output logic [4:0]              res_idx,
   output logic                    overflow
);

   unpack_state_e           state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [63:0]             slice_q, slice_d;
   logic                    in_ready_q, in_ready_d;
   logic                    overflow_q, overflow_d;
   logic                    res_valid_q, res_valid_d;
   logic                    res_last_q, res_last_d;
   logic [4:0]              res_idx_q, res_idx_d;
   logic signed [OUT_W-1:0] res_data_q, res_data_d;

   logic                    byte_acc;
   logic [63:0]             slice_shift;
   logic [63:0]             deq_slice;
   logic [4:0]              deq_idx;
   logic signed [OUT_W-1:0] deq_res;

   // The dequantiser looks at the slice/index that will be loaded this edge,
   // so residual 0 is ready one cycle after the eighth byte.
   assign byte_acc    = (state_q == ST_COLLECT) && in_valid && in_ready_q;
   assign slice_shift = {slice_q[55:0], in_data};
   assign deq_slice   = byte_acc ? slice_shift : slice_q;
   assign deq_idx     = (state_q == ST_COLLECT) ? 5'd0 : res_idx_q + 5'd1;

   qoa_dequant #(.OUT_W(OUT_W)) u_dequant (
      .sf_quant (slice_sf(deq_slice)),
      .q        (residual_field(deq_slice, deq_idx)),
      .res      (deq_res)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      slice_d     = slice_q;
      res_valid_d = res_valid_q;
      res_last_d  = res_last_q;
      res_idx_d   = res_idx_q;
      res_data_d  = res_data_q;
      overflow_d  = overflow_q | (in_valid & ~in_ready_q);

      unique case (state_q)
         ST_COLLECT: begin
            if (byte_acc) begin
               slice_d = slice_shift;
               if (cnt_q == 3'(QOA_SLICE_BYTES - 1)) begin
                  cnt_d       = '0;
                  state_d     = ST_EMIT;
                  res_valid_d = 1'b1;
                  res_idx_d   = deq_idx;
                  res_last_d  = 1'b0;
                  res_data_d  = deq_res;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         ST_EMIT: begin
            if (res_valid_q && res_ready) begin
               if (res_last_q) begin
                  state_d     = ST_COLLECT;
                  res_valid_d = 1'b0;
                  res_last_d  = 1'b0;
                  res_idx_d   = '0;
                  res_data_d  = '0;
               end else begin
                  res_idx_d  = deq_idx;
                  res_last_d = (deq_idx == 5'(QOA_SLICE_RESIDUALS - 1));
                  res_data_d = deq_res;
               end
            end
         end
         default: state_d = ST_COLLECT;
      endcase

      in_ready_d = (state_d == ST_COLLECT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_COLLECT;
         cnt_q       <= '0;
         slice_q     <= '0;
         in_ready_q  <= 1'b0;
         overflow_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         res_idx_q   <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         slice_q     <= slice_d;
         in_ready_q  <= in_ready_d;
         overflow_q  <= overflow_d;
         res_valid_q <= res_valid_d;
         res_last_q  <= res_last_d;
         res_idx_q   <= res_idx_d;
         res_data_q  <= res_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign overflow  = overflow_q;
   assign res_valid = res_valid_q;
   assign res_last  = res_last_q;
   assign res_idx   = res_idx_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_qoa_slice_unpack.sv
// Directed bench for qoa_slice_unpack: table of slices with hand-computed
// residuals, plus stall, overflow and mid-slice reset sequences.
module tb_qoa_slice_unpack;

   logic              clk;
   logic              rst;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic signed [15:0] res_data;
   logic              res_valid;
   logic              res_ready;
   logic              res_last;
   logic [4:0]        res_idx;
   logic              overflow;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [63:0]      slice;
      logic [7:0][15:0] e;      // expected residuals 0..7 (e[0] = residual 0)
      int               erest;  // expected residuals 8..19
   } vec_t;

   vec_t vecs[6];

   qoa_slice_unpack #(.OUT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_last  (res_last),
      .res_idx   (res_idx),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bytes(input logic [63:0] s, input int nbytes);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("in_ready_before_send", int'(in_ready), 1);
      for (int i = 0; i < nbytes; i++) begin
         in_valid = 1'b1;
         in_data  = s[63-8*i -: 8];
         tick();
      end
      in_valid = 1'b0;
   endtask

   // stall_at / pulse_at / abort_at: residual index at which to stall res_ready
   // for 5 cycles, pulse a stray byte, or assert rst (-1 = never).
   task automatic run_slice(input logic [63:0] s, input logic [7:0][15:0] e,
                            input int erest, input int stall_at,
                            input int pulse_at, input int abort_at);
      int ex;
      send_bytes(s, 8);
      for (int k = 0; k < 20; k++) begin
         ex = (k < 8) ? int'($signed(e[k])) : erest;
         chk("res_valid", int'(res_valid), 1);
         chk("res_idx",   int'(res_idx), k);
         chk("res_data",  int'(res_data), ex);
         chk("res_last",  int'(res_last), int'(k == 19));
         if (k == abort_at) begin
            rst      = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'h5A;
            tick();
            rst      = 1'b0;
            in_valid = 1'b0;
            chk("abort_res_valid", int'(res_valid), 0);
            chk("abort_res_data",  int'(res_data), 0);
            chk("abort_res_idx",   int'(res_idx), 0);
            chk("abort_in_ready",  int'(in_ready), 0);
            chk("abort_overflow",  int'(overflow), 0);
            for (int c = 0; c < 12; c++) begin
               tick();
               chk("abort_no_residual", int'(res_valid), 0);
            end
            chk("abort_in_ready_back", int'(in_ready), 1);
            return;
         end
         if (k == stall_at) begin
            res_ready = 1'b0;
            repeat (5) begin
               tick();
               chk("stall_valid", int'(res_valid), 1);
               chk("stall_idx",   int'(res_idx), k);
               chk("stall_data",  int'(res_data), ex);
            end
            res_ready = 1'b1;
         end
         if (k == pulse_at) begin
            in_valid = 1'b1;
            in_data  = 8'hAB;
         end
         tick();
         in_valid = 1'b0;
         if (k == pulse_at) chk("overflow_set", int'(overflow), 1);
      end
      chk("end_res_valid", int'(res_valid), 0);
      chk("end_in_ready",  int'(in_ready), 1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      res_ready = 1'b1;

      vecs[0] = '{slice: 64'h0000_0000_0000_0000, e: {8{16'd1}},     erest: 1};
      vecs[1] = '{slice: 64'hFFFF_FFFF_FFFF_FFFF, e: {8{16'hC800}},  erest: -14336};
      vecs[2] = '{slice: 64'hF000_0000_0000_0000, e: {8{16'd1536}},  erest: 1536};
      vecs[3] = '{slice: 64'h1053_9770_0000_0000,
                  e: {16'hFFCF, 16'd49, 16'hFFE0, 16'd32,
                      16'hFFEE, 16'd18, 16'hFFFB, 16'd5},
                  erest: 5};
      vecs[4] = '{slice: 64'h7924_9249_2492_4924, e: {8{16'd1368}},  erest: 1368};
      vecs[5] = '{slice: 64'hA492_4924_9249_2492, e: {8{16'd1828}},  erest: 1828};

      repeat (3) tick();
      chk("rst_in_ready",  int'(in_ready), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_data",  int'(res_data), 0);
      chk("rst_res_idx",   int'(res_idx), 0);
      chk("rst_res_last",  int'(res_last), 0);
      chk("rst_overflow",  int'(overflow), 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", int'(in_ready), 1);

      for (int v = 0; v < 6; v++)
         run_slice(vecs[v].slice, vecs[v].e, vecs[v].erest, -1, -1, -1);

      run_slice(vecs[3].slice, vecs[3].e, vecs[3].erest, 3, -1, -1);

      chk("overflow_clear_before", int'(overflow), 0);
      run_slice(vecs[0].slice, vecs[0].e, vecs[0].erest, -1, 5, -1);
      chk("overflow_sticky_1", int'(overflow), 1);
      run_slice(vecs[2].slice, vecs[2].e, vecs[2].erest, -1, -1, -1);
      chk("overflow_sticky_2", int'(overflow), 1);

      send_bytes(64'hFFFF_FFFF_FFFF_FFFF, 5);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("partial_rst_overflow", int'(overflow), 0);
      chk("partial_rst_in_ready", int'(in_ready), 0);
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("partial_no_residual", int'(res_valid), 0);
      end
      run_slice(vecs[3].slice, vecs[3].e, vecs[3].erest, -1, -1, -1);

      run_slice(vecs[1].slice, vecs[1].e, vecs[1].erest, -1, -1, 10);
      run_slice(vecs[0].slice, vecs[0].e, vecs[0].erest, -1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
